// File: rtl/prog_loader_if.sv
// Boot-loader bus: UART byte stream in, instruction-memory write port and
// boot status out. The master side is the loader, the slave side its environment.
interface prog_loader_if;
  logic        go;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [9:0]  i_addr;
  logic [31:0] i_wdata;
  logic        i_we;
  logic        start_pulse;
  logic        boot_done;
  logic [31:0] checksum;

  modport master (
    input  go,
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output i_addr,
    output i_wdata,
    output i_we,
    output start_pulse,
    output boot_done,
    output checksum
  );

  modport slave (
    output go,
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  i_addr,
    input  i_wdata,
    input  i_we,
    input  start_pulse,
    input  boot_done,
    input  checksum
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: receives a big-endian word count followed by that many
// big-endian words, writes them to instruction memory, then releases the CPU.
module prog_loader (
  input  logic         clk,
  input  logic         rst,
  prog_loader_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
    DONE
  } state_t;

  localparam logic [10:0] MAX_WORDS = 11'd1024;

  state_t      state_reg;
  logic [31:0] count_reg;
  logic [31:0] word_reg;
  logic [1:0]  byte_cnt_reg;
  logic [10:0] eff_count_reg;
  // One bit wider than i_addr so index 1023 + 1 compares cleanly to 1024.
  logic [10:0] word_idx_reg;

  logic        rx_ready_reg;
  logic [9:0]  i_addr_reg;
  logic [31:0] i_wdata_reg;
  logic        i_we_reg;
  logic        start_pulse_reg;
  logic        boot_done_reg;
  logic [31:0] checksum_reg;

  logic        byte_take;
  logic [31:0] count_next;
  logic [31:0] word_next;
  logic [10:0] eff_count_next;
  logic [10:0] word_idx_next;

  always_comb begin
    byte_take      = bus.rx_valid && rx_ready_reg;
    count_next     = {count_reg[23:0], bus.rx_data};
    word_next      = {word_reg[23:0], bus.rx_data};
    eff_count_next = (count_next > 32'd1024) ? MAX_WORDS : count_next[10:0];
    word_idx_next  = word_idx_reg + 11'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      count_reg       <= '0;
      word_reg        <= '0;
      byte_cnt_reg    <= '0;
      eff_count_reg   <= '0;
      word_idx_reg    <= '0;
      rx_ready_reg    <= 1'b0;
      i_addr_reg      <= '0;
      i_wdata_reg     <= '0;
      i_we_reg        <= 1'b0;
      start_pulse_reg <= 1'b0;
      boot_done_reg   <= 1'b0;
      checksum_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.go) begin
            state_reg    <= LEN;
            rx_ready_reg <= 1'b1;
            count_reg    <= '0;
            byte_cnt_reg <= '0;
            word_idx_reg <= '0;
          end
        end

        LEN: begin
          if (byte_take) begin
            count_reg    <= count_next;
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            if (byte_cnt_reg == 2'd3) begin
              eff_count_reg <= eff_count_next;
              if (count_next == 32'd0) begin
                state_reg       <= DONE;
                rx_ready_reg    <= 1'b0;
                start_pulse_reg <= 1'b1;
                boot_done_reg   <= 1'b1;
              end else begin
                state_reg <= DATA;
              end
            end
          end
        end

        DATA: begin
          if (byte_take) begin
            word_reg     <= word_next;
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            if (byte_cnt_reg == 2'd3) begin
              state_reg    <= WRITE;
              rx_ready_reg <= 1'b0;
              i_we_reg     <= 1'b1;
              i_addr_reg   <= word_idx_reg[9:0];
              i_wdata_reg  <= word_next;
            end
          end
        end

        WRITE: begin
          // The memory samples the word on this edge, so the sum moves with it.
          i_we_reg     <= 1'b0;
          checksum_reg <= checksum_reg + i_wdata_reg;
          if (word_idx_next == eff_count_reg) begin
            state_reg       <= DONE;
            start_pulse_reg <= 1'b1;
            boot_done_reg   <= 1'b1;
          end else begin
            word_idx_reg <= word_idx_next;
            state_reg    <= DATA;
            rx_ready_reg <= 1'b1;
          end
        end

        DONE: begin
          start_pulse_reg <= 1'b0;
        end

        default: begin
          state_reg    <= IDLE;
          rx_ready_reg <= 1'b0;
          i_we_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_ready    = rx_ready_reg;
  assign bus.i_addr      = i_addr_reg;
  assign bus.i_wdata     = i_wdata_reg;
  assign bus.i_we        = i_we_reg;
  assign bus.start_pulse = start_pulse_reg;
  assign bus.boot_done   = boot_done_reg;
  assign bus.checksum    = checksum_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized directed bench for prog_loader; expected writes and checksum come
// from decoding the byte stream directly.
module tb_prog_loader;

  logic clk;
  logic rst;

  prog_loader_if bus ();

  prog_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;

  logic [7:0]  stream[$];
  logic [9:0]  obs_addr[$];
  logic [31:0] obs_data[$];
  logic [9:0]  exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] exp_sum;
  int          pulses;
  int          ready_in_write;

  // Write-port monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.i_we) begin
        obs_addr.push_back(bus.i_addr);
        obs_data.push_back(bus.i_wdata);
        if (bus.rx_ready) ready_in_write++;
      end
      if (bus.start_pulse) pulses++;
    end
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic clear_obs();
    obs_addr.delete();
    obs_data.delete();
    pulses = 0;
    ready_in_write = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.go = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_load();
    bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
  endtask

  // gap_mode: 0 none, 1 random idle cycles, 2 one idle cycle before every byte
  task automatic send_byte(input logic [7:0] b, input int gap_mode);
    int guard;
    guard = 0;
    if (gap_mode == 2) begin
      bus.rx_valid = 1'b0;
      bus.rx_data = 8'($urandom);
      @(negedge clk);
    end else if (gap_mode == 1) begin
      while ($urandom_range(0, 2) == 0) begin
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'($urandom);
        @(negedge clk);
      end
    end
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready) begin
      @(negedge clk);
      guard++;
      if (guard > 100) begin
        check("rx_ready_timeout", 64'd1, 64'd0);
        bus.rx_valid = 1'b0;
        return;
      end
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_range(input int first, input int last, input int gap_mode);
    for (int i = first; i < last; i++) send_byte(stream[i], gap_mode);
  endtask

  // Reference model: decode the stream as count + words, clamp to 1024.
  task automatic build_expected();
    logic [31:0] n;
    int eff;
    exp_addr.delete();
    exp_data.delete();
    exp_sum = 32'd0;
    n = {stream[0], stream[1], stream[2], stream[3]};
    eff = (n > 32'd1024) ? 1024 : int'(n);
    for (int i = 0; i < eff; i++) begin
      logic [31:0] w;
      w = {stream[4 + 4*i], stream[5 + 4*i], stream[6 + 4*i], stream[7 + 4*i]};
      exp_addr.push_back(10'(i));
      exp_data.push_back(w);
      exp_sum = exp_sum + w;
    end
  endtask

  task automatic finish_and_check(input string name);
    int guard;
    int ready_seen;
    int n_before;
    guard = 0;
    while (!bus.boot_done && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({name, "_boot_done"}, 64'(bus.boot_done), 64'd1);
    repeat (3) @(negedge clk);
    // DONE must ignore go and refuse further bytes.
    n_before = obs_data.size();
    ready_seen = 0;
    bus.go = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'h5A;
    repeat (5) begin
      @(negedge clk);
      if (bus.rx_ready) ready_seen++;
    end
    bus.go = 1'b0;
    bus.rx_valid = 1'b0;
    check({name, "_done_rx_ready"}, 64'(ready_seen), 64'd0);
    check({name, "_done_no_write"}, 64'(obs_data.size()), 64'(n_before));
    check({name, "_boot_done_held"}, 64'(bus.boot_done), 64'd1);
    check({name, "_start_pulses"}, 64'(pulses), 64'd1);
    check({name, "_i_we_done"}, 64'(bus.i_we), 64'd0);
    check({name, "_ready_in_write"}, 64'(ready_in_write), 64'd0);
    check({name, "_n_writes"}, 64'(obs_data.size()), 64'(exp_data.size()));
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      check({name, "_addr"}, 64'(obs_addr[i]), 64'(exp_addr[i]));
      check({name, "_data"}, 64'(obs_data[i]), 64'(exp_data[i]));
    end
    check({name, "_checksum"}, 64'(bus.checksum), 64'(exp_sum));
    if (exp_data.size() > 0) begin
      check({name, "_addr_hold"}, 64'(bus.i_addr), 64'(exp_addr[exp_addr.size()-1]));
      check({name, "_wdata_hold"}, 64'(bus.i_wdata), 64'(exp_data[exp_data.size()-1]));
    end
    $display("[TB] %s: %0d writes, checksum %08h", name, obs_data.size(), bus.checksum);
  endtask

  task automatic push_word(input logic [31:0] w);
    stream.push_back(w[31:24]);
    stream.push_back(w[23:16]);
    stream.push_back(w[15:8]);
    stream.push_back(w[7:0]);
  endtask

  task automatic run_stream(input string name, input int gap_mode);
    do_reset();
    clear_obs();
    build_expected();
    start_load();
    send_range(0, stream.size(), gap_mode);
    finish_and_check(name);
  endtask

  initial begin
    int ready_seen;
    int nw;
    tests = 0;
    fails = 0;
    pulses = 0;
    ready_in_write = 0;
    rst = 1'b1;
    bus.go = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    repeat (2) @(negedge clk);

    check("rst_rx_ready", 64'(bus.rx_ready), 64'd0);
    check("rst_i_addr", 64'(bus.i_addr), 64'd0);
    check("rst_i_wdata", 64'(bus.i_wdata), 64'd0);
    check("rst_i_we", 64'(bus.i_we), 64'd0);
    check("rst_start_pulse", 64'(bus.start_pulse), 64'd0);
    check("rst_boot_done", 64'(bus.boot_done), 64'd0);
    check("rst_checksum", 64'(bus.checksum), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Bytes offered in IDLE with go low are never taken.
    clear_obs();
    ready_seen = 0;
    bus.rx_valid = 1'b1;
    repeat (10) begin
      bus.rx_data = 8'($urandom);
      @(negedge clk);
      if (bus.rx_ready) ready_seen++;
    end
    bus.rx_valid = 1'b0;
    check("idle_rx_ready", 64'(ready_seen), 64'd0);
    check("idle_no_write", 64'(obs_data.size()), 64'd0);
    $display("[TB] idle with go=0: rx_ready high %0d cycles", ready_seen);

    stream.delete();
    push_word(32'd2);
    push_word(32'h12345678);
    push_word(32'h9ABCDEF0);
    run_stream("two_words", 0);
    check("two_words_sum_const", 64'(bus.checksum), 64'h00000000ACF13568);

    stream.delete();
    push_word(32'd0);
    run_stream("zero_count", 1);

    stream.delete();
    push_word(32'd1);
    push_word(32'hDEADBEEF);
    run_stream("toggle_valid", 2);

    // Count of 2048 is clamped to 1024 words.
    stream.delete();
    push_word(32'h00000800);
    for (int i = 0; i < 1024; i++) push_word($urandom);
    run_stream("clamp_2048", 0);

    for (int t = 0; t < 3; t++) begin
      stream.delete();
      nw = $urandom_range(1, 24);
      push_word(32'(nw));
      for (int i = 0; i < nw; i++) push_word($urandom);
      run_stream("random", 1);
    end

    // Reset mid-word discards the partial word; a fresh load then succeeds.
    do_reset();
    clear_obs();
    stream.delete();
    push_word(32'd1);
    push_word(32'hCAFEF00D);
    start_load();
    send_range(0, 6, 0);
    rst = 1'b1;
    #1;
    check("async_rst_rx_ready", 64'(bus.rx_ready), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ready_seen = 0;
    bus.rx_valid = 1'b1;
    repeat (5) begin
      bus.rx_data = 8'($urandom);
      @(negedge clk);
      if (bus.rx_ready) ready_seen++;
    end
    bus.rx_valid = 1'b0;
    check("post_rst_no_consume", 64'(ready_seen), 64'd0);
    check("post_rst_no_write", 64'(obs_data.size()), 64'd0);
    build_expected();
    start_load();
    send_range(0, stream.size(), 1);
    finish_and_check("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: observed running expected finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; ports listed clock and reset first.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 go  input  1  level; sampled in IDLE, starts a load.
REQ-005 rx_data  input  8  received byte from UART receiver.
REQ-006 rx_valid  input  1  rx_data holds an unconsumed byte.
REQ-007 rx_ready  output  1  loader can accept a byte; byte consumed on an edge where rx_valid and rx_ready are both 1.
REQ-008 i_addr  output  10  instruction-memory write address (word index).
REQ-009 i_wdata  output  32  instruction-memory write data.
REQ-010 i_we  output  1  instruction-memory write enable, one cycle per word.
REQ-011 start_pulse  output  1  one-cycle pulse releasing the CPU fetch stage.
REQ-012 boot_done  output  1  level; load complete.
REQ-013 checksum  output  32  running modulo-2^32 sum of all written words.

Function
REQ-014 Stream format SHALL be: 4-byte word count N, then N words of 4 bytes each; all multi-byte fields big-endian (first byte -> bits 31:24).
REQ-015 States SHALL be IDLE, LEN, DATA, WRITE, DONE.
REQ-016 IDLE: rx_ready=0; go=1 at an edge -> LEN next cycle.
REQ-017 LEN: rx_ready=1; each consumed byte shifts into a 32-bit count register (count = {count[23:0], rx_data}); after 4th byte -> DATA, or DONE if N=0.
REQ-018 Effective count SHALL be min(N, 1024); excess words are never requested.
REQ-019 DATA: rx_ready=1; bytes shift into a word register the same way; 2-bit byte counter; after 4th byte -> WRITE.
REQ-020 WRITE: exactly one cycle; rx_ready=0, i_we=1, i_addr=word index, i_wdata=assembled word; checksum += word on the same edge.
REQ-021 After WRITE, word index SHALL increment; if index+1 == effective count -> DONE, else DATA.
REQ-022 Latency: i_we asserts the cycle after the edge consuming a word's 4th byte.
REQ-023 rx_valid=0 in LEN/DATA SHALL stall with no state change; no timeout.
REQ-024 i_we SHALL be 0 in every state except WRITE; i_addr/i_wdata hold last values otherwise.
REQ-025 DONE: start_pulse=1 for exactly the first cycle in DONE; boot_done=1 for as long as in DONE; rx_ready=0; go ignored; exit only via rst.
REQ-026 Index 1023 write followed by completion SHALL not wrap i_addr to 0 with i_we=1.
REQ-027 go deasserting after LEN is entered SHALL have no effect.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE and outputs rx_ready=0, i_addr=0, i_wdata=0, i_we=0, start_pulse=0, boot_done=0, checksum=0; count, word and byte counters cleared.
REQ-029 rst mid-word or mid-count SHALL discard partial data; no i_we issued for it after release.
REQ-030 After rst release, no byte SHALL be consumed until go=1 is sampled.

Verification
REQ-031 go=1, bytes 00 00 00 02, 12 34 56 78, 9A BC DE F0 -> writes (0,12345678),(1,9ABCDEF0); checksum=ACF13568; start_pulse one cycle; boot_done=1.
REQ-032 go=1, count 00 00 00 00 -> DONE directly, no i_we, start_pulse one cycle, checksum=0.
REQ-033 count 00 00 08 00 (2048), 1024 words streamed -> 1024 writes, addr 0..1023, last at 1023; rx_ready=0 after 1024th word.
REQ-034 rx_valid toggled 1/0 every cycle with count 1, word DEADBEEF -> single write (0,DEADBEEF); rx_ready never 1 in WRITE.
REQ-035 rst asserted after 2 bytes of word 1, released, go=1, full 1-word stream CAFEF00D -> only write (0,CAFEF00D); checksum=CAFEF00D.
REQ-036 Bytes on rx_valid while go=0 in IDLE -> rx_ready=0, nothing consumed, no i_we.
